// File: rtl/cross_bar_slave_mem.sv
// +--------------------------------------------------------------------------+
// | cross_bar_slave_mem: slave-port memory responder with delayed ack and    |
// | fixed-latency read response. Optional stats: SLAVE_MEM_STATS_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cross_bar_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ACK_DELAY = 1,
  parameter int RESP_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata
`ifdef SLAVE_MEM_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              cmd_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [RESP_LAT-1:0] vld;
  logic [DATA_W-1:0]   dly [RESP_LAT];

  logic commit;
  logic unused_addr;

  assign commit      = (state == ACK);
  assign unused_addr = ^addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      ack     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            idx_q   <= addr[IDX_W-1:0];
            cmd_q   <= cmd;
            wdata_q <= wdata;
            if (ACK_DELAY == 0) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACK;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          // req is deliberately not sampled here so a held request is not re-accepted
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cmd_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Data stages only load on reads, so the last stage changes exactly when a valid read arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < RESP_LAT; k++) begin
        dly[k] <= '0;
      end
    end else begin
      vld[0] <= commit && !cmd_q;
      if (commit && !cmd_q) begin
        dly[0] <= mem[idx_q];
      end
      for (int k = 1; k < RESP_LAT; k++) begin
        vld[k] <= vld[k-1];
        dly[k] <= dly[k-1];
      end
    end
  end

  assign resp  = vld[RESP_LAT-1];
  assign rdata = dly[RESP_LAT-1];

`ifdef SLAVE_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= 16'd0;
      rd_cnt <= 16'd0;
    end else if (stats_clr) begin
      wr_cnt <= 16'd0;
      rd_cnt <= 16'd0;
    end else begin
      if (commit && cmd_q) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (resp) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
